// File: rtl/regfile_decode.sv
// Y86-64 decode stage: source-register selection, a register file with
// write-first bypass from the E and M writeback ports, and a one-entry output register.
module regfile_decode #(
  parameter int               WIDTH    = 64,
  parameter int               NREGS    = 15,
  parameter int               RSP_ID   = 4,
  parameter logic [WIDTH-1:0] RSP_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic [3:0]       dstE,
  input  logic [WIDTH-1:0] valE,
  input  logic [3:0]       dstM,
  input  logic [WIDTH-1:0] valM,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [3:0]       srcA,
  output logic [3:0]       srcB,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB,
  output logic             ins_err
);

  localparam logic [4:0] NREGS_L = 5'(NREGS);
  localparam logic [3:0] RSP     = 4'(RSP_ID);
  localparam logic [3:0] RNONE   = 4'hF;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready is a function of out_valid/out_ready only, so the stage runs
  // at one instruction per cycle while the consumer keeps taking results.
  logic accept;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  function automatic logic id_ok(input logic [3:0] id);
    return {1'b0, id} < NREGS_L;
  endfunction

  logic e_ok, m_ok;
  assign e_ok = id_ok(dstE);
  assign m_ok = id_ok(dstM);

  // Register storage: 16 slots so any 4-bit ID indexes safely; slots at or
  // above NREGS are tied to zero and never stored.
  logic [WIDTH-1:0] regs [16];

  for (genvar g = 0; g < 16; g++) begin : g_reg
    if (g < NREGS) begin : g_impl
      always_ff @(posedge clk) begin
        if (rst) begin
          regs[g] <= (g == RSP_ID) ? RSP_INIT : '0;
        end else if (m_ok && dstM == 4'(g)) begin
          regs[g] <= valM;
        end else if (e_ok && dstE == 4'(g)) begin
          regs[g] <= valE;
        end
      end
    end else begin : g_absent
      assign regs[g] = '0;
    end
  end

  // M is checked before E so a popq %rsp sees the loaded value.
  function automatic logic [WIDTH-1:0] read_op(input logic [3:0] id);
    logic [WIDTH-1:0] r;
    r = '0;
    if (id_ok(id)) begin
      if (m_ok && dstM == id)      r = valM;
      else if (e_ok && dstE == id) r = valE;
      else                         r = regs[id];
    end
    return r;
  endfunction

  logic [3:0]       src_a_d, src_b_d;
  logic [WIDTH-1:0] val_a_d, val_b_d;
  logic             err_d;

  always_comb begin
    src_a_d = RNONE;
    src_b_d = RNONE;
    case (icode)
      4'h2, 4'h4, 4'h6, 4'hA: src_a_d = rA;
      4'h9, 4'hB:             src_a_d = RSP;
      default:                src_a_d = RNONE;
    endcase
    case (icode)
      4'h4, 4'h5, 4'h6:       src_b_d = rB;
      4'h8, 4'h9, 4'hA, 4'hB: src_b_d = RSP;
      default:                src_b_d = RNONE;
    endcase
  end

  assign err_d   = icode > 4'hB;
  assign val_a_d = read_op(src_a_d);
  assign val_b_d = read_op(src_b_d);

  // Captured operands are frozen; later writes to the same register are the
  // consumer's hazard to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_icode <= 4'h0;
      srcA      <= RNONE;
      srcB      <= RNONE;
      valA      <= '0;
      valB      <= '0;
      ins_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_icode <= icode;
      srcA      <= src_a_d;
      srcB      <= src_b_d;
      valA      <= val_a_d;
      valB      <= val_b_d;
      ins_err   <= err_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_decode.sv
// Directed bench for regfile_decode: a vector table of single-cycle decodes
// followed by hand-written hold, drain and mid-stream reset sequences.
module tb_regfile_decode;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   icode, ra, rb, dst_e, dst_m;
  logic [W-1:0] val_e, val_m;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_icode, src_a, src_b;
  logic [W-1:0] val_a, val_b;
  logic         ins_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  regfile_decode #(
    .WIDTH(W), .NREGS(15), .RSP_ID(4), .RSP_INIT(64'h100)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .rA(ra), .rB(rb),
    .dstE(dst_e), .valE(val_e), .dstM(dst_m), .valM(val_m),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_icode(out_icode), .srcA(src_a), .srcB(src_b),
    .valA(val_a), .valB(val_b), .ins_err(ins_err)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // ---- checking ----
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---- driver tasks ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] de, input logic [W-1:0] ve,
                       input logic [3:0] dm, input logic [W-1:0] vm);
    icode = ic; ra = a; rb = b;
    dst_e = de; val_e = ve; dst_m = dm; val_m = vm;
  endtask

  typedef struct {
    string        name;
    logic [3:0]   ic, a, b, de;
    logic [W-1:0] ve;
    logic [3:0]   dm;
    logic [W-1:0] vm;
    logic [3:0]   e_src_a, e_src_b;
    logic [W-1:0] e_val_a, e_val_b;
    logic         e_err;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // Register state along the table: r7=9, r3=55 then AA, r4=20, r5=77.
    vecs[0]  = '{"opq_rsp",      4'h6, 4'h4, 4'h4, 4'hF, 64'h0,    4'hF, 64'h0,   4'h4, 4'h4, 64'h100, 64'h100, 1'b0};
    vecs[1]  = '{"irmovq_w7",    4'h3, 4'hF, 4'h7, 4'h7, 64'h9,    4'hF, 64'h0,   4'hF, 4'hF, 64'h0,   64'h0,   1'b0};
    vecs[2]  = '{"rmmovq_byp",   4'h4, 4'h3, 4'h7, 4'h3, 64'h55,   4'hF, 64'h0,   4'h3, 4'h7, 64'h55,  64'h9,   1'b0};
    vecs[3]  = '{"popq_em_same", 4'hB, 4'h4, 4'hF, 4'h4, 64'h10,   4'h4, 64'h20,  4'h4, 4'h4, 64'h20,  64'h20,  1'b0};
    vecs[4]  = '{"ret_stored",   4'h9, 4'hF, 4'hF, 4'hF, 64'h0,    4'hF, 64'h0,   4'h4, 4'h4, 64'h20,  64'h20,  1'b0};
    vecs[5]  = '{"irmovq_rb2",   4'h3, 4'hF, 4'h2, 4'hF, 64'h0,    4'hF, 64'h0,   4'hF, 4'hF, 64'h0,   64'h0,   1'b0};
    vecs[6]  = '{"bad_icode_d",  4'hD, 4'h1, 4'h2, 4'hF, 64'h0,    4'hF, 64'h0,   4'hF, 4'hF, 64'h0,   64'h0,   1'b1};
    vecs[7]  = '{"cmovxx",       4'h2, 4'h3, 4'h7, 4'hF, 64'h0,    4'hF, 64'h0,   4'h3, 4'hF, 64'h55,  64'h0,   1'b0};
    vecs[8]  = '{"mrmovq_mprio", 4'h5, 4'h7, 4'h3, 4'h3, 64'hBB,   4'h3, 64'hAA,  4'hF, 4'h3, 64'h0,   64'hAA,  1'b0};
    vecs[9]  = '{"pushq",        4'hA, 4'h3, 4'hF, 4'h5, 64'h77,   4'hF, 64'h0,   4'h3, 4'h4, 64'hAA,  64'h20,  1'b0};
    vecs[10] = '{"call",         4'h8, 4'hF, 4'hF, 4'hF, 64'hDEAD, 4'hF, 64'hBEEF, 4'hF, 4'h4, 64'h0,  64'h20,  1'b0};
    vecs[11] = '{"opq_r5_r7",    4'h6, 4'h5, 4'h7, 4'hF, 64'h0,    4'hF, 64'h0,   4'h5, 4'h7, 64'h77,  64'h9,   1'b0};
    vecs[12] = '{"halt",         4'h0, 4'h1, 4'h2, 4'hF, 64'h0,    4'hF, 64'h0,   4'hF, 4'hF, 64'h0,   64'h0,   1'b0};
    vecs[13] = '{"bad_icode_c",  4'hC, 4'h6, 4'h6, 4'hF, 64'h0,    4'hF, 64'h0,   4'hF, 4'hF, 64'h0,   64'h0,   1'b1};
  end

  // ---- stimulus ----
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(4'h0, 4'hF, 4'hF, 4'hF, '0, 4'hF, '0);
    step();
    step();
    rst = 1'b0;

    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_out_icode", W'(out_icode), W'(0));
    check("rst_srcA",      W'(src_a),     W'(4'hF));
    check("rst_srcB",      W'(src_b),     W'(4'hF));
    check("rst_valA",      val_a,         W'(0));
    check("rst_valB",      val_b,         W'(0));
    check("rst_ins_err",   W'(ins_err),   W'(0));

    // Table: one accept per cycle with the consumer always ready.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].ic, vecs[i].a, vecs[i].b, vecs[i].de, vecs[i].ve, vecs[i].dm, vecs[i].vm);
      exp_q.push_back(vecs[i].e_val_a);
      exp_q.push_back(vecs[i].e_val_b);
      step();
      check({vecs[i].name, "_out_valid"}, W'(out_valid), W'(1));
      check({vecs[i].name, "_in_ready"},  W'(in_ready),  W'(1));
      check({vecs[i].name, "_out_icode"}, W'(out_icode), W'(vecs[i].ic));
      check({vecs[i].name, "_srcA"},      W'(src_a),     W'(vecs[i].e_src_a));
      check({vecs[i].name, "_srcB"},      W'(src_b),     W'(vecs[i].e_src_b));
      check({vecs[i].name, "_valA"},      val_a,         exp_q.pop_front());
      check({vecs[i].name, "_valB"},      val_b,         exp_q.pop_front());
      check({vecs[i].name, "_ins_err"},   W'(ins_err),   W'(vecs[i].e_err));
    end

    // Hold: load opq r5,r3, then stall the consumer for 3 cycles.
    drive(4'h6, 4'h5, 4'h3, 4'hF, '0, 4'hF, '0);
    step();
    out_ready = 1'b0;
    drive(4'h6, 4'h7, 4'h7, 4'hF, '0, 4'hF, '0);
    #1;
    for (int c = 0; c < 3; c++) begin
      check("hold_in_ready",  W'(in_ready),  W'(0));
      check("hold_out_valid", W'(out_valid), W'(1));
      check("hold_srcA",      W'(src_a),     W'(4'h5));
      check("hold_srcB",      W'(src_b),     W'(4'h3));
      check("hold_valA",      val_a,         W'(64'h77));
      check("hold_valB",      val_b,         W'(64'hAA));
      step();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", W'(in_ready), W'(1));
    step();
    check("reload_out_valid", W'(out_valid), W'(1));
    check("reload_srcA",      W'(src_a),     W'(4'h7));
    check("reload_valA",      val_a,         W'(64'h9));
    check("reload_valB",      val_b,         W'(64'h9));

    // Drain with no new request.
    in_valid = 1'b0;
    step();
    check("drain_out_valid", W'(out_valid), W'(0));
    check("drain_in_ready",  W'(in_ready),  W'(1));

    // Mid-stream reset: output held, r5=0x77; reset also ignores a write to r5.
    in_valid = 1'b1; out_ready = 1'b0;
    drive(4'hA, 4'h5, 4'hF, 4'hF, '0, 4'hF, '0);
    step();
    check("pre_rst_out_valid", W'(out_valid), W'(1));
    check("pre_rst_valA",      val_a,         W'(64'h77));
    rst = 1'b1;
    drive(4'h6, 4'h1, 4'h1, 4'h5, 64'h99, 4'hF, '0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_srcA",      W'(src_a),     W'(4'hF));
    check("midrst_valA",      val_a,         W'(0));
    in_valid = 1'b1; out_ready = 1'b1;
    drive(4'h6, 4'h5, 4'h4, 4'hF, '0, 4'hF, '0);
    step();
    check("post_rst_r5",  val_a, W'(0));
    check("post_rst_rsp", val_b, W'(64'h100));
    in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_decode.md
# regfile_decode

Parametrised decode stage with an embedded Y86-64 register file. It decodes `icode`/`rA`/`rB` into source register IDs and reads two operands, with write-first bypass from the two writeback ports (E and M). It captures the result in a one-entry output register with a valid/ready handshake. It sits between fetch and execute in the SEQ/PIPE processor.

## Interface
- `WIDTH`, 64: register/data width in bits.
- `NREGS`, 15: number of implemented registers. IDs `0..NREGS-1` are valid; IDs `>= NREGS` (incl. 4'hF = RNONE) are absent. Legal range 5..15.
- `RSP_ID`, 4: stack-pointer register ID.
- `RSP_INIT`, 0: reset value of register `RSP_ID`.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: decode request present.
- `in_ready` out 1: request accepted this cycle when `in_valid && in_ready`.
- `icode` in 4: instruction code.
- `rA` in 4: register A specifier.
- `rB` in 4: register B specifier.
- `dstE` in 4: E-port write ID; absent ID means no write.
- `valE` in WIDTH: E-port write data.
- `dstM` in 4: M-port write ID; absent ID means no write.
- `valM` in WIDTH: M-port write data.
- `out_valid` out 1: output register holds a decoded instruction.
- `out_ready` in 1: consumer takes output when `out_valid && out_ready`.
- `out_icode` out 4: captured icode.
- `srcA` out 4: captured source-A ID.
- `srcB` out 4: captured source-B ID.
- `valA` out WIDTH: captured operand A.
- `valB` out WIDTH: captured operand B.
- `ins_err` out 1: captured icode > 4'hB.

## Operation
- Source select, combinational on inputs:
  - srcA is `rA` for cmovxx(2), rmmovq(4), opq(6), pushq(A).
  - srcA is `RSP_ID` for popq(B) and ret(9).
  - srcA is 4'hF for all other icodes.
  - srcB is `rB` for rmmovq(4), mrmovq(5), opq(6).
  - srcB is `RSP_ID` for pushq(A), popq(B), call(8), ret(9).
  - srcB is 4'hF for all other icodes.
- Operand read: an absent ID reads 0.
  - If the ID equals `dstM` (valid), the read returns `valM`.
  - Otherwise, if it equals `dstE` (valid), the read returns `valE`.
  - Otherwise the read returns the stored register.
  - M has priority over E (popq %rsp semantics).
- Register write: each rising edge, valid `dstE` writes `valE` and valid `dstM` writes `valM`.
  - When `dstE == dstM`, only `valM` is stored.
  - Writes happen regardless of handshake state.
- Output register: on accept, capture `icode`, `srcA`, `srcB`, the bypassed `valA`/`valB`, and `ins_err`. Set `out_valid`.
  - Captured values are frozen. Later writes to the same register do not update them; hazard handling belongs to the consumer.
- Handshake:
  - `in_ready = !out_valid || out_ready`, so a back-to-back flow runs at 1 instruction/cycle.
  - Output drain without a new accept clears `out_valid`.
  - Simultaneous drain and accept reloads the register; `out_valid` stays 1.
  - While the output is held (`out_valid && !out_ready`), outputs are stable.
- Invalid icode: `srcA`/`srcB` = 4'hF, `valA`/`valB` = 0, `ins_err` = 1. It is still accepted and handed downstream.

## Timing
- Reset (`rst` high at an edge):
  - All registers become 0, except `RSP_ID` = `RSP_INIT`.
  - `out_valid` = 0. `out_icode` = 0. `srcA`/`srcB` = 4'hF. `valA`/`valB` = 0. `ins_err` = 0.
  - Writeback ports and requests presented in that cycle are ignored.
  - Reset mid-stream discards the held output.
- `in_ready` is 1 in the first cycle after reset.
- Latency: request accepted at edge N; outputs valid after edge N.
- Write-to-read:
  - A write presented in cycle N is visible to a decode accepted in the same cycle N (bypass).
  - It is also visible to every later decode (storage).
- `in_ready` depends only on `out_valid` and `out_ready`. There is no combinational path from `in_valid` to `in_ready`.

## Test plan
- Reset with `RSP_INIT`=0x100, then opq with rA=4, rB=4 -> after accept, `valA` = `valB` = 0x100, `srcA` = `srcB` = 4, `out_valid` = 1.
- In one cycle, write `dstE`=3 with 0x55 while decoding rmmovq rA=3, rB=7 (r7 previously written with 0x9) -> `valA`=0x55 (bypass), `valB`=0x9.
- `dstE`=`dstM`=4, `valE`=0x10, `valM`=0x20, with popq decoded the same cycle -> `valA`=`valB`=0x20. A later ret reads 0x20.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0 and outputs stable. Then `out_ready`=1 -> the next instruction loads on the same edge and `out_valid` stays 1.
- irmovq rB=2 -> `srcA`=4'hF, `valA`=0. icode=4'hD -> `ins_err`=1, `valA`=`valB`=0.
- Assert `rst` while `out_valid`=1 and r5=0x77 -> next cycle `out_valid`=0, and a read of r5 returns 0.
